// File: rtl/thread_fetch_scheduler_if.sv
// Fetch-scheduler control bundle: redirect/miss/clear inputs from the pipeline and the fetch request to IF.
// The master drives the control inputs; the slave (the scheduler) returns the registered fetch request.
interface thread_fetch_scheduler_if;
  logic        stall;
  logic        redirect_valid;
  logic [1:0]  redirect_tid;
  logic [31:0] redirect_pc;
  logic        miss_set;
  logic [1:0]  miss_tid;
  logic [31:0] miss_pc;
  logic        miss_clear;
  logic [1:0]  clear_tid;
  logic        fetch_valid;
  logic [1:0]  fetch_tid;
  logic [31:0] fetch_pc;
  logic [3:0]  thread_ready;

  modport master (
    output stall, redirect_valid, redirect_tid, redirect_pc,
    output miss_set, miss_tid, miss_pc, miss_clear, clear_tid,
    input  fetch_valid, fetch_tid, fetch_pc, thread_ready
  );

  modport slave (
    input  stall, redirect_valid, redirect_tid, redirect_pc,
    input  miss_set, miss_tid, miss_pc, miss_clear, clear_tid,
    output fetch_valid, fetch_tid, fetch_pc, thread_ready
  );
endinterface

// File: rtl/thread_fetch_scheduler.sv
// Round-robin 4-thread fetch scheduler; one registered fetch request per cycle (1-cycle latency).
// stall freezes the fetch request and rotation; redirect/miss/clear updates still land during stall.
module thread_fetch_scheduler #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0] THREAD_STRIDE = 32'h0000_0400
) (
  input  logic                      clk,
  input  logic                      nReset,
  thread_fetch_scheduler_if.slave   bus
);

  logic [31:0] pc_q [4];
  logic [31:0] pc_d [4];
  logic [3:0]  pending_q, pending_d;
  logic [1:0]  last_tid_q, last_tid_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic [1:0]  fetch_tid_q, fetch_tid_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [3:0]  thread_ready_q;

  logic [3:0]  eligible;
  logic [1:0]  sel;
  logic [1:0]  cand;
  logic        any_elig;
  logic        advance;
  logic [31:0] redir_pc;
  logic [31:0] miss_pc;
  logic [31:0] sel_base;

  assign redir_pc = {bus.redirect_pc[31:2], 2'b00};
  assign miss_pc  = {bus.miss_pc[31:2], 2'b00};

  // A thread being parked this cycle is already excluded from selection.
  always_comb begin
    eligible = 4'b0000;
    for (int t = 0; t < 4; t++) begin
      eligible[t] = ~pending_q[t] & ~(bus.miss_set && (bus.miss_tid == 2'(t)));
    end
  end

  // Walk the search order from farthest to nearest so the nearest eligible thread wins.
  always_comb begin
    sel      = last_tid_q;
    cand     = last_tid_q;
    any_elig = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_tid_q + 2'(k);
      if (eligible[cand]) begin
        sel      = cand;
        any_elig = 1'b1;
      end
    end
  end

  assign advance  = ~bus.stall & any_elig;
  assign sel_base = (bus.redirect_valid && (bus.redirect_tid == sel)) ? redir_pc : pc_q[sel];

  always_comb begin
    for (int t = 0; t < 4; t++) begin
      pc_d[t] = pc_q[t];
      if (bus.miss_set && (bus.miss_tid == 2'(t)))
        pc_d[t] = miss_pc;
      if (bus.redirect_valid && (bus.redirect_tid == 2'(t)))
        pc_d[t] = redir_pc;
      if (advance && (sel == 2'(t)))
        pc_d[t] = sel_base + 32'd4;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (bus.miss_clear)
      pending_d[bus.clear_tid] = 1'b0;
    if (bus.miss_set)
      pending_d[bus.miss_tid] = 1'b1;
  end

  always_comb begin
    fetch_valid_d = fetch_valid_q;
    fetch_tid_d   = fetch_tid_q;
    fetch_pc_d    = fetch_pc_q;
    last_tid_d    = last_tid_q;
    if (!bus.stall) begin
      fetch_valid_d = any_elig;
      if (any_elig) begin
        fetch_tid_d = sel;
        fetch_pc_d  = sel_base;
        last_tid_d  = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nReset) begin
      for (int t = 0; t < 4; t++) begin
        pc_q[t] <= RESET_PC + THREAD_STRIDE * 32'(t);
      end
      pending_q      <= 4'b0000;
      last_tid_q     <= 2'd3;
      fetch_valid_q  <= 1'b0;
      fetch_tid_q    <= 2'd0;
      fetch_pc_q     <= 32'd0;
      thread_ready_q <= 4'b1111;
    end else begin
      for (int t = 0; t < 4; t++) begin
        pc_q[t] <= pc_d[t];
      end
      pending_q      <= pending_d;
      last_tid_q     <= last_tid_d;
      fetch_valid_q  <= fetch_valid_d;
      fetch_tid_q    <= fetch_tid_d;
      fetch_pc_q     <= fetch_pc_d;
      thread_ready_q <= ~pending_d;
    end
  end

  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.fetch_tid    = fetch_tid_q;
  assign bus.fetch_pc     = fetch_pc_q;
  assign bus.thread_ready = thread_ready_q;

endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Directed bench for thread_fetch_scheduler: rotation, parking, redirect bypass, stall, wrap and reset.
// Expected fetch sequences below are hand-derived from the default RESET_PC/THREAD_STRIDE.
module tb_thread_fetch_scheduler;

  logic clk;
  logic nReset;
  int   checks;
  int   errors;

  thread_fetch_scheduler_if bus ();

  thread_fetch_scheduler dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  task automatic idle();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_tid   = 2'd0;
    bus.redirect_pc    = 32'd0;
    bus.miss_set       = 1'b0;
    bus.miss_tid       = 2'd0;
    bus.miss_pc        = 32'd0;
    bus.miss_clear     = 1'b0;
    bus.clear_tid      = 2'd0;
  endtask

  // Advance one edge and settle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_fetch(input string tag, input logic [1:0] tid, input logic [31:0] pc);
    check({tag, ".valid"}, bus.fetch_valid, 1'b1);
    check({tag, ".tid"}, bus.fetch_tid, tid);
    check({tag, ".pc"}, bus.fetch_pc, pc);
  endtask

  task automatic fetch(input string tag, input logic [1:0] tid, input logic [31:0] pc);
    step();
    exp_fetch(tag, tid, pc);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".valid"}, bus.fetch_valid, 1'b0);
    check({tag, ".tid"}, bus.fetch_tid, 2'd0);
    check({tag, ".pc"}, bus.fetch_pc, 32'd0);
    check({tag, ".ready"}, bus.thread_ready, 4'b1111);
  endtask

  task automatic do_reset();
    idle();
    nReset = 1'b1;
    step();
    nReset = 1'b0;
  endtask

  task automatic base_rotation(input string tag);
    fetch({tag, "0"}, 2'd0, 32'h000);
    fetch({tag, "1"}, 2'd1, 32'h400);
    fetch({tag, "2"}, 2'd2, 32'h800);
    fetch({tag, "3"}, 2'd3, 32'hC00);
    fetch({tag, "4"}, 2'd0, 32'h004);
    fetch({tag, "5"}, 2'd1, 32'h404);
  endtask

  initial begin
    clk    = 1'b0;
    checks = 0;
    errors = 0;
    idle();
    nReset = 1'b1;
    step();
    step();
    check_reset_state("rst");
    nReset = 1'b0;
    base_rotation("rot");

    // Park tid1 after the first round, then release it.
    do_reset();
    fetch("m_a", 2'd0, 32'h000);
    fetch("m_b", 2'd1, 32'h400);
    fetch("m_c", 2'd2, 32'h800);
    fetch("m_d", 2'd3, 32'hC00);
    bus.miss_set = 1'b1; bus.miss_tid = 2'd1; bus.miss_pc = 32'h400;
    fetch("m_e", 2'd0, 32'h004);
    idle();
    check("m_ready_set", bus.thread_ready, 4'b1101);
    fetch("m_f", 2'd2, 32'h804);
    fetch("m_g", 2'd3, 32'hC04);
    fetch("m_h", 2'd0, 32'h008);
    check("m_ready_hold", bus.thread_ready, 4'b1101);
    bus.miss_clear = 1'b1; bus.clear_tid = 2'd1;
    fetch("m_i", 2'd2, 32'h808);
    idle();
    check("m_ready_clr", bus.thread_ready, 4'b1111);
    fetch("m_j", 2'd3, 32'hC08);
    fetch("m_k", 2'd0, 32'h00C);
    fetch("m_l", 2'd1, 32'h400);

    // Park every thread, one per cycle; tid3 retry PC has low bits to be dropped.
    bus.miss_set = 1'b1; bus.miss_tid = 2'd0; bus.miss_pc = 32'h100;
    fetch("p_a", 2'd2, 32'h80C);
    bus.miss_tid = 2'd1; bus.miss_pc = 32'h200;
    fetch("p_b", 2'd3, 32'hC0C);
    bus.miss_tid = 2'd2; bus.miss_pc = 32'h300;
    fetch("p_c", 2'd3, 32'hC10);
    bus.miss_tid = 2'd3; bus.miss_pc = 32'h3FF;
    step();
    check("p_none.valid", bus.fetch_valid, 1'b0);
    idle();
    check("p_none.ready", bus.thread_ready, 4'b0000);
    step();
    check("p_idle.valid", bus.fetch_valid, 1'b0);
    bus.miss_clear = 1'b1; bus.clear_tid = 2'd2;
    step();
    check("p_clr_edge.valid", bus.fetch_valid, 1'b0);
    idle();
    fetch("p_d", 2'd2, 32'h300);
    fetch("p_e", 2'd2, 32'h304);
    // Same-tid set and clear: set wins.
    bus.miss_set = 1'b1; bus.miss_tid = 2'd2; bus.miss_pc = 32'h500;
    bus.miss_clear = 1'b1; bus.clear_tid = 2'd2;
    step();
    check("sc_edge.valid", bus.fetch_valid, 1'b0);
    idle();
    step();
    check("sc_after.valid", bus.fetch_valid, 1'b0);
    check("sc_after.ready", bus.thread_ready, 4'b0000);

    // Redirect bypass into the thread selected in the same cycle.
    do_reset();
    bus.redirect_valid = 1'b1; bus.redirect_tid = 2'd0; bus.redirect_pc = 32'h1236;
    fetch("r_a", 2'd0, 32'h1234);
    idle();
    fetch("r_b", 2'd1, 32'h400);
    fetch("r_c", 2'd2, 32'h800);
    fetch("r_d", 2'd3, 32'hC00);
    fetch("r_e", 2'd0, 32'h1238);

    // Three stalled cycles with a redirect of tid3 in the middle.
    bus.stall = 1'b1;
    fetch("s_a", 2'd0, 32'h1238);
    bus.redirect_valid = 1'b1; bus.redirect_tid = 2'd3; bus.redirect_pc = 32'h2000;
    fetch("s_b", 2'd0, 32'h1238);
    idle();
    bus.stall = 1'b1;
    fetch("s_c", 2'd0, 32'h1238);
    bus.stall = 1'b0;
    fetch("s_d", 2'd1, 32'h404);
    fetch("s_e", 2'd2, 32'h804);
    fetch("s_f", 2'd3, 32'h2000);

    // PC wrap at the top of the address space.
    bus.redirect_valid = 1'b1; bus.redirect_tid = 2'd0; bus.redirect_pc = 32'hFFFF_FFFC;
    fetch("w_a", 2'd0, 32'hFFFF_FFFC);
    idle();
    fetch("w_b", 2'd1, 32'h408);
    fetch("w_c", 2'd2, 32'h808);
    fetch("w_d", 2'd3, 32'h2004);
    fetch("w_e", 2'd0, 32'h000);

    // Redirect and miss on the same tid: redirect PC wins, thread still parks.
    bus.miss_set = 1'b1; bus.miss_tid = 2'd1; bus.miss_pc = 32'h600;
    bus.redirect_valid = 1'b1; bus.redirect_tid = 2'd1; bus.redirect_pc = 32'h700;
    fetch("rm_a", 2'd2, 32'h80C);
    idle();
    check("rm_ready", bus.thread_ready, 4'b1101);
    bus.miss_clear = 1'b1; bus.clear_tid = 2'd1;
    fetch("rm_b", 2'd3, 32'h2008);
    idle();
    fetch("rm_c", 2'd0, 32'h004);
    fetch("rm_d", 2'd1, 32'h700);

    // Reset mid-stream while a miss and a stall are active.
    nReset = 1'b1;
    bus.stall = 1'b1;
    bus.miss_set = 1'b1; bus.miss_tid = 2'd0; bus.miss_pc = 32'h900;
    step();
    check_reset_state("mrst");
    idle();
    nReset = 1'b0;
    base_rotation("rrot");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
